// File: rtl/mdu_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline with a multi-cycle MUL/DIV unit in EX.
// Handles load-use stalls, taken-branch flushes, MDU launch/freeze with a watchdog,
// and a saturating stall-cycle counter.
module mdu_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MduOpE,
    input  logic             MduDone,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MduStart,
    output logic             MduKill,
    output logic             MduErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam int unsigned     TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               err_q, err_d;
    logic               kill_q, kill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic lw_stall;
    logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start, kill;

    // Load in E whose destination feeds either source of the instruction in D.
    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

    // Next-state, watchdog and control decode; controls are zeroed while in reset.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        kill_d  = 1'b0;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        start   = 1'b0;
        kill    = 1'b0;

        case (state_q)
            IDLE: begin
                // After a kill, E still holds the aborted MDU op: flush it, never relaunch it.
                if (MduOpE && !kill_q) begin
                    start   = 1'b1;
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    tmr_d   = '0;
                    state_d = BUSY;
                end else begin
                    stall_f = lw_stall;
                    stall_d = lw_stall;
                    flush_e = lw_stall || PCSrcE || kill_q;
                    flush_d = PCSrcE;
                end
            end
            BUSY: begin
                if (MduDone) begin
                    state_d = IDLE;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    tmr_d   = tmr_q + TMR_W'(1);
                    if (tmr_q == TMR_LAST) begin
                        kill    = 1'b1;
                        kill_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rst_n) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
            flush_m = 1'b0;
            start   = 1'b0;
            kill    = 1'b0;
        end

        cnt_d = cnt_q;
        if (stall_f && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, watchdog, sticky error, kill follow-up and perf counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign StallF     = stall_f;
    assign StallD     = stall_d;
    assign StallE     = stall_e;
    assign FlushD     = flush_d;
    assign FlushE     = flush_e;
    assign FlushM     = flush_m;
    assign MduStart   = start;
    assign MduKill    = kill;
    assign MduErr     = rst_n && err_q;
    assign StallCount = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_mdu_hazard_ctrl.sv
// Scoreboard bench for mdu_hazard_ctrl (TIMEOUT=8, CNT_W=4).
// Stimulus pushes hand-computed expected outputs per cycle; a monitor pops and compares.
module tb_mdu_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // Control vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,MduStart,MduKill,MduErr}
    localparam logic [8:0] C_NONE   = 9'b000000000;
    localparam logic [8:0] C_LW     = 9'b110010000;
    localparam logic [8:0] C_BR     = 9'b000110000;
    localparam logic [8:0] C_BRLW   = 9'b110110000;
    localparam logic [8:0] C_LAUNCH = 9'b111001100;
    localparam logic [8:0] C_BUSY   = 9'b111001000;
    localparam logic [8:0] C_KILL   = 9'b111001010;
    localparam logic [8:0] C_ERR    = 9'b000000001;
    localparam logic [8:0] C_POSTK  = 9'b000010001;

    logic clk, rst_n;
    logic [4:0] Rs1D, Rs2D, RdE;
    logic ResultSrcE0, PCSrcE, MduOpE, MduDone;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MduStart, MduKill, MduErr;
    logic [CNT_W-1:0] StallCount;

    typedef struct {
        logic [8:0]       ctl;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    mdu_hazard_ctrl #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MduOpE(MduOpE), .MduDone(MduDone),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MduStart(MduStart), .MduKill(MduKill), .MduErr(MduErr),
        .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue its expected outputs.
    task automatic drv(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rde, input logic ld, input logic br,
                       input logic op, input logic done,
                       input logic [8:0] ctl, input int cnt, input string name);
        exp_t e;
        #1;
        rst_n = rst; Rs1D = rs1; Rs2D = rs2; RdE = rde;
        ResultSrcE0 = ld; PCSrcE = br; MduOpE = op; MduDone = done;
        e.ctl = ctl; e.cnt = CNT_W'(cnt); e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] got;
            e   = exp_q.pop_front();
            got = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MduStart, MduKill, MduErr};
            checks++;
            if (got !== e.ctl || StallCount !== e.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         e.name, got, StallCount, e.ctl, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; Rs1D = '0; Rs2D = '0; RdE = '0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MduOpE = 1'b0; MduDone = 1'b0;
        @(posedge clk);

        // Reset forces all controls low even with every hazard input active.
        drv(0, 5, 0, 5, 1, 1, 1, 1, C_NONE, 0, "reset_outputs");
        // Load-use and branch cases in IDLE.
        drv(1, 5, 0, 5, 1, 0, 0, 0, C_LW,   0, "lw_rs1");
        drv(1, 0, 0, 0, 1, 0, 0, 0, C_NONE, 1, "lw_rd0");
        drv(1, 3, 7, 7, 1, 0, 0, 0, C_LW,   1, "lw_rs2");
        drv(1, 0, 0, 0, 0, 1, 0, 0, C_BR,   2, "branch");
        drv(1, 5, 0, 5, 1, 1, 0, 0, C_BRLW, 2, "branch_lw");
        drv(1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 3, "idle_quiet");

        // MDU normal: launch (lwStall ignored), done in 3rd BUSY cycle.
        drv(1, 5, 0, 5, 1, 0, 1, 0, C_LAUNCH, 3, "mdu_launch");
        drv(1, 0, 0, 0, 0, 0, 1, 0, C_BUSY,   4, "mdu_busy1");
        drv(1, 0, 0, 0, 0, 0, 1, 0, C_BUSY,   5, "mdu_busy2");
        drv(1, 0, 0, 0, 0, 0, 1, 1, C_NONE,   6, "mdu_done");
        // MduDone in IDLE is ignored; new E instruction is a branch.
        drv(1, 0, 0, 0, 0, 1, 0, 1, C_BR,     6, "idle_done_ignored");

        // Timeout: kill in 8th BUSY cycle, then flush E with no relaunch.
        drv(1, 0, 0, 0, 0, 0, 1, 0, C_LAUNCH, 6, "to_launch");
        for (int i = 1; i <= 7; i++)
            drv(1, 0, 0, 0, 0, 0, 1, 0, C_BUSY, 6 + i, $sformatf("to_busy%0d", i));
        drv(1, 0, 0, 0, 0, 0, 1, 0, C_KILL,  14, "to_kill");
        drv(1, 0, 0, 0, 0, 0, 1, 0, C_POSTK, 15, "to_flushE");
        drv(1, 0, 0, 0, 0, 0, 0, 0, C_ERR,   15, "to_err_sticky");

        // Done/timeout race after a clean reset; PCSrcE at launch is ignored.
        drv(0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, "reset_clears_err");
        drv(1, 0, 0, 0, 0, 1, 1, 0, C_LAUNCH, 0, "race_launch");
        for (int i = 1; i <= 7; i++)
            drv(1, 0, 0, 0, 0, 0, 1, 0, C_BUSY, i, $sformatf("race_busy%0d", i));
        drv(1, 0, 0, 0, 0, 0, 1, 1, C_NONE, 8, "race_done");
        drv(1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 8, "race_no_err");

        // Reset in BUSY cycle 2: outputs zero, no kill, back to IDLE.
        drv(1, 0, 0, 0, 0, 0, 1, 0, C_LAUNCH, 8, "rst_launch");
        drv(1, 0, 0, 0, 0, 0, 1, 0, C_BUSY,   9, "rst_busy1");
        drv(0, 0, 0, 0, 0, 0, 1, 0, C_NONE,   0, "rst_midbusy");
        drv(1, 0, 0, 0, 0, 0, 0, 0, C_NONE,   0, "rst_idle");

        // 20 load-use stall cycles: counter saturates at 15.
        for (int i = 0; i < 20; i++)
            drv(1, 9, 0, 9, 1, 0, 0, 0, C_LW, (i > 15) ? 15 : i, $sformatf("sat_%0d", i));
        drv(1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 15, "sat_hold");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        stim_done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
